// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage MIPS core.
//
// Purpose:
//   - Resolves load-use and HI/LO (mult/div busy) hazards by stalling IF/ID and
//     injecting a bubble into ID/EX.
//   - Flushes IF/ID and ID/EX on a taken branch/jump resolved in EX.
//   - Selects EX operand forwarding sources (MEM has priority over WB).
//   - Sequences the multi-cycle mult/div unit with a busy down-counter.
//   - Keeps a saturating count of stalled cycles for performance debug.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   rs_D, rt_D, uses_rt_D      source fields / rt-usage of the ID instruction
//   hilo_use_D                 ID instruction needs the HI/LO unit
//   rs_E, rt_E                 source fields of the EX instruction
//   mem_read_E                 EX instruction is a load
//   md_start_E                 EX instruction starts mult/div
//   branch_taken_E             EX branch/jump resolved taken
//   wreg_M, reg_write_M        MEM destination and write enable
//   wreg_W, reg_write_W        WB destination and write enable
//   stall_F, stall_D           hold PC / hold IF/ID
//   flush_D, flush_E           bubble IF/ID / bubble ID/EX
//   fwd_a_E, fwd_b_E           operand selects: 00 regfile, 01 WB, 10 MEM
//   md_busy, md_done           mult/div busy level / completion pulse
//   stall_cnt                  saturating stalled-cycle counter
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic             uses_rt_D,
  input  logic             hilo_use_D,
  input  logic [4:0]       rs_E,
  input  logic [4:0]       rt_E,
  input  logic             mem_read_E,
  input  logic             md_start_E,
  input  logic             branch_taken_E,
  input  logic [4:0]       wreg_M,
  input  logic             reg_write_M,
  input  logic [4:0]       wreg_W,
  input  logic             reg_write_W,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MD_W = $clog2(MD_LAT + 1);
  localparam logic [MD_W-1:0]  MD_LOAD = MD_W'(MD_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic             md_done_q, md_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_s;
  logic mh_s;

  // Forwarding source select for one EX operand; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       wr_m,
    input logic [4:0] dst_m,
    input logic       wr_w,
    input logic [4:0] dst_w
  );
    logic [1:0] sel;
    if (wr_m && (dst_m != 5'd0) && (dst_m == src)) begin
      sel = FWD_MEM;
    end else if (wr_w && (dst_w != 5'd0) && (dst_w == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Operand forwarding selects.
  always_comb begin
    fwd_a_E = fwd_sel(rs_E, reg_write_M, wreg_M, reg_write_W, wreg_W);
    fwd_b_E = fwd_sel(rt_E, reg_write_M, wreg_M, reg_write_W, wreg_W);
  end

  // Hazard detection: load-use and HI/LO access while the unit is busy.
  always_comb begin
    md_busy = (md_cnt_q != {MD_W{1'b0}});
    lu_s    = mem_read_E && (rt_E != 5'd0) &&
              ((rt_E == rs_D) || (uses_rt_D && (rt_E == rt_D)));
    mh_s    = hilo_use_D && md_busy;
  end

  // Stall/flush priority: a taken branch beats any stall so the redirect
  // fetches the target instead of holding the wrong-path instruction.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if (branch_taken_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (mh_s || lu_s) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end else begin
      stall_F = 1'b0;
      stall_D = 1'b0;
    end
  end

  // Mult/div counter next state; a start while busy is ignored because the
  // HI/LO hazard keeps a second mult/div from reaching EX.
  always_comb begin
    md_cnt_d  = md_cnt_q;
    md_done_d = 1'b0;
    if (md_cnt_q == {MD_W{1'b0}}) begin
      if (md_start_E) begin
        md_cnt_d = MD_LOAD;
      end else begin
        md_cnt_d = md_cnt_q;
      end
    end else begin
      md_cnt_d  = md_cnt_q - MD_W'(1);
      md_done_d = (md_cnt_q == MD_W'(1));
    end
  end

  // Saturating stalled-cycle counter next state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_D && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset aborts any mult/div operation without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q    <= {MD_W{1'b0}};
      md_done_q   <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      md_cnt_q    <= md_cnt_d;
      md_done_q   <= md_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_done   = md_done_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl with MD_LAT=4, CNT_W=3.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, wreg_M, wreg_W;
  logic       uses_rt_D, hilo_use_D, mem_read_E, md_start_E, branch_taken_E;
  logic       reg_write_M, reg_write_W;
  logic       stall_F, stall_D, flush_D, flush_E;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic       md_busy, md_done;
  logic [2:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_D(rs_D), .rt_D(rt_D), .uses_rt_D(uses_rt_D), .hilo_use_D(hilo_use_D),
    .rs_E(rs_E), .rt_E(rt_E), .mem_read_E(mem_read_E), .md_start_E(md_start_E),
    .branch_taken_E(branch_taken_E),
    .wreg_M(wreg_M), .reg_write_M(reg_write_M),
    .wreg_W(wreg_W), .reg_write_W(reg_write_W),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and step 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_D = 5'd0; rt_D = 5'd0; uses_rt_D = 1'b0; hilo_use_D = 1'b0;
    rs_E = 5'd0; rt_E = 5'd0; mem_read_E = 1'b0; md_start_E = 1'b0;
    branch_taken_E = 1'b0;
    wreg_M = 5'd0; reg_write_M = 1'b0; wreg_W = 5'd0; reg_write_W = 1'b0;
  endtask

  task automatic check_ctrl(input string tag, input logic [3:0] exp_sf_sd_fd_fe);
    #1;
    check_eq(tag, {28'd0, stall_F, stall_D, flush_D, flush_E}, {28'd0, exp_sf_sd_fd_fe});
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check_eq("rst_md_busy",   {31'd0, md_busy}, 32'd0);
    check_eq("rst_md_done",   {31'd0, md_done}, 32'd0);
    check_eq("rst_stall_cnt", {29'd0, stall_cnt}, 32'd0);
    check_ctrl("rst_ctrl", 4'b0000);
    rst_n = 1'b1;
    tick();

    // Forwarding
    reg_write_M = 1'b1; wreg_M = 5'd5; rs_E = 5'd5; reg_write_W = 1'b1; wreg_W = 5'd5;
    #1 check_eq("fwd_a_mem_prio", {30'd0, fwd_a_E}, 32'd2);
    reg_write_M = 1'b0;
    #1 check_eq("fwd_a_wb", {30'd0, fwd_a_E}, 32'd1);
    reg_write_M = 1'b1; wreg_M = 5'd0; rs_E = 5'd0; wreg_W = 5'd0;
    #1 check_eq("fwd_a_r0", {30'd0, fwd_a_E}, 32'd0);
    wreg_M = 5'd3; rt_E = 5'd6; wreg_W = 5'd6;
    #1 check_eq("fwd_b_wb", {30'd0, fwd_b_E}, 32'd1);
    wreg_M = 5'd6;
    #1 check_eq("fwd_b_mem", {30'd0, fwd_b_E}, 32'd2);
    clear_inputs();

    // Load-use, rs match: one-cycle stall
    mem_read_E = 1'b1; rt_E = 5'd8; rs_D = 5'd8;
    check_ctrl("lu_rs_stall", 4'b1101);
    tick();
    clear_inputs();
    check_ctrl("lu_released", 4'b0000);
    check_eq("lu_stall_cnt", {29'd0, stall_cnt}, 32'd1);
    mem_read_E = 1'b1; rt_E = 5'd0; rs_D = 5'd0;
    check_ctrl("lu_r0_nostall", 4'b0000);
    rt_E = 5'd4; rs_D = 5'd1; rt_D = 5'd4; uses_rt_D = 1'b1;
    check_ctrl("lu_rt_stall", 4'b1101);
    uses_rt_D = 1'b0;
    check_ctrl("lu_rt_unused", 4'b0000);
    clear_inputs();

    // Mult/div with HI/LO user held in ID
    rst_n = 1'b0; #1 rst_n = 1'b1;
    md_start_E = 1'b1; hilo_use_D = 1'b1;
    check_ctrl("md_start_nostall", 4'b0000);
    tick();
    md_start_E = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("md_busy_%0d", i), {31'd0, md_busy}, 32'd1);
      check_eq($sformatf("md_stall_%0d", i), {31'd0, stall_D}, 32'd1);
      check_eq($sformatf("md_nodone_%0d", i), {31'd0, md_done}, 32'd0);
      tick();
    end
    check_eq("md_busy_clear", {31'd0, md_busy}, 32'd0);
    check_eq("md_done_pulse", {31'd0, md_done}, 32'd1);
    check_ctrl("md_stall_clear", 4'b0000);
    check_eq("md_stall_cnt", {29'd0, stall_cnt}, 32'd4);
    hilo_use_D = 1'b0;
    tick();
    check_eq("md_done_once", {31'd0, md_done}, 32'd0);

    // Branch overrides load-use
    mem_read_E = 1'b1; rt_E = 5'd8; rs_D = 5'd8; branch_taken_E = 1'b1;
    check_ctrl("br_over_lu", 4'b0011);
    tick();
    check_eq("br_stall_cnt", {29'd0, stall_cnt}, 32'd4);
    clear_inputs();

    // Reset two cycles into an operation
    md_start_E = 1'b1;
    tick();
    md_start_E = 1'b0; hilo_use_D = 1'b1;
    tick();
    tick();
    check_eq("mid_busy_pre", {31'd0, md_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_busy_rst", {31'd0, md_busy}, 32'd0);
    check_eq("mid_cnt_rst", {29'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;
    hilo_use_D = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("mid_nodone_%0d", i), {31'd0, md_done}, 32'd0);
    end

    // Saturation with CNT_W=3
    mem_read_E = 1'b1; rt_E = 5'd8; rs_D = 5'd8;
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    check_eq("sat_stall_cnt", {29'd0, stall_cnt}, 32'd7);
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Drives stall and flush enables for the IF/ID and ID/EX pipeline registers.
- Generates EX-stage operand forwarding selects.
- Sequences a multi-cycle multiply/divide unit through an internal busy counter, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MD_LAT, 32: cycles the mult/div unit is busy after a start.
- CNT_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs_D  in  5  rs field of instruction in ID
- rt_D  in  5  rt field of instruction in ID
- uses_rt_D  in  1  ID instruction reads rt as a source
- hilo_use_D  in  1  ID instruction is mfhi/mflo/mult/div (needs HI/LO unit)
- rs_E  in  5  rs of instruction in EX
- rt_E  in  5  rt of instruction in EX
- mem_read_E  in  1  EX instruction is a load
- md_start_E  in  1  EX instruction starts mult/div
- branch_taken_E  in  1  branch/jump resolved taken in EX
- wreg_M  in  5  destination register in MEM
- reg_write_M  in  1  MEM writes register file
- wreg_W  in  5  destination register in WB
- reg_write_W  in  1  WB writes register file
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID register
- flush_D  out  1  clear IF/ID register to bubble
- flush_E  out  1  clear ID/EX register to bubble
- fwd_a_E  out  2  operand A select: 00 regfile, 01 WB, 10 MEM
- fwd_b_E  out  2  operand B select, same encoding
- md_busy  out  1  mult/div unit busy
- md_done  out  1  one-cycle pulse when the unit completes
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_n=0): md counter=0, md_busy=0, md_done=0, stall_cnt=0. Combinational outputs follow their equations with md_busy=0.
- Forwarding (combinational):
  - fwd_a_E=10 if reg_write_M && wreg_M!=0 && wreg_M==rs_E.
  - Else 01 if reg_write_W && wreg_W!=0 && wreg_W==rs_E.
  - Else 00.
  - fwd_b_E uses the same rules with rt_E.
  - MEM has priority over WB.
- Load-use hazard: lu = mem_read_E && rt_E!=0 && (rt_E==rs_D || (uses_rt_D && rt_E==rt_D)).
- Mult/div hazard: mh = hilo_use_D && md_busy.
- Mult/div counter:
  - md_start_E while counter==0 loads counter=MD_LAT on the next edge.
  - Otherwise a nonzero counter decrements by 1 each cycle.
  - md_busy = (counter!=0), combinational from the register.
  - md_done is registered: 1 in the cycle after counter goes 1->0, else 0.
  - md_start_E while md_busy is ignored; it cannot occur legally because mh stalls it in ID.
- Control priority, evaluated each cycle:
  1. branch_taken_E: flush_D=1, flush_E=1, stall_F=0, stall_D=0. Overrides lu/mh so the redirect fetches the target.
  2. mh or lu: stall_F=1, stall_D=1, flush_E=1, flush_D=0.
  3. Otherwise all four outputs are 0.
- Load-use stall lasts exactly 1 cycle: the load advances to MEM, then lu drops.
- MD stall holds until the cycle in which counter==0.
- stall_cnt increments on every edge where stall_D=1 and saturates at all-ones.
- Reset asserted mid-MD aborts the operation: md_busy drops immediately and no md_done is issued.
- Register 0 never triggers forwarding or a load-use stall.

Test Plan:
- Forwarding:
  - reg_write_M=1, wreg_M=5, rs_E=5, reg_write_W=1, wreg_W=5 -> fwd_a_E=10.
  - Drop reg_write_M -> 01.
  - wreg_M=0, rs_E=0 -> 00.
- Load-use:
  - mem_read_E=1, rt_E=8, rs_D=8 -> stall_F=stall_D=flush_E=1 for exactly one cycle; stall_cnt 0->1.
  - Same with rt_E=0 -> no stall.
- Mult/div, MD_LAT=4:
  - md_start_E pulse -> md_busy=1 for 4 cycles.
  - hilo_use_D=1 held -> stall for those 4 cycles.
  - md_done pulses in the cycle after busy clears.
  - stall_cnt=4.
- Branch over stall: lu=1 and branch_taken_E=1 in the same cycle -> flush_D=flush_E=1, stall_F=stall_D=0; stall_cnt unchanged.
- Reset mid-op:
  - Assert rst_n=0 two cycles into an MD_LAT=4 operation -> md_busy=0 asynchronously, stall_cnt=0.
  - No md_done after release.
- Saturation: CNT_W=3, hold lu for 10 cycles -> stall_cnt stops at 7.
